// File: rtl/elevator_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared types and helpers for the SCAN elevator controller.
//   car_state_t : controller states (IDLE, MOVE, OPEN, CLOSE, ESTOP)
//   dir_t       : travel direction (UP, DOWN)
//   width_of()  : counter/index width for a range of n values, never below 1
//   flip_dir()  : opposite travel direction
// -----------------------------------------------------------------------------
package elevator_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MOVE  = 3'd1,
        OPEN  = 3'd2,
        CLOSE = 3'd3,
        ESTOP = 3'd4
    } car_state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic dir_t flip_dir(input dir_t d);
        return (d == UP) ? DOWN : UP;
    endfunction

endpackage

// File: rtl/elevator_scan_ctrl_scan_dir_sel.sv
// -----------------------------------------------------------------------------
// scan_dir_sel
// Combinational SCAN helper: classifies the pending call bitmap relative to a
// floor and a direction.
//   pending_i       : latched call bitmap
//   current_floor_i : reference floor
//   dir_i           : reference direction
//   hit_here_o      : call pending at the reference floor
//   any_ahead_o     : call pending strictly beyond the floor in dir_i
//   any_behind_o    : call pending strictly behind the floor w.r.t. dir_i
// -----------------------------------------------------------------------------
module scan_dir_sel
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 5,
    parameter int FW         = 3
) (
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  logic [FW-1:0]         current_floor_i,
    input  dir_t                  dir_i,
    output logic                  hit_here_o,
    output logic                  any_ahead_o,
    output logic                  any_behind_o
);

    logic above_s;
    logic below_s;

    // Split the bitmap into above / at / below the reference floor, then map onto the direction.
    always_comb begin
        above_s    = 1'b0;
        below_s    = 1'b0;
        hit_here_o = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (FW'(i) > current_floor_i) begin
                above_s = above_s | pending_i[i];
            end else if (FW'(i) < current_floor_i) begin
                below_s = below_s | pending_i[i];
            end else begin
                hit_here_o = pending_i[i];
            end
        end
        if (dir_i == UP) begin
            any_ahead_o  = above_s;
            any_behind_o = below_s;
        end else begin
            any_ahead_o  = below_s;
            any_behind_o = above_s;
        end
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// -----------------------------------------------------------------------------
// elevator_scan_ctrl
// Elevator car controller serving latched floor calls in SCAN order, with
// internal door timing, per-floor travel time and emergency stop.
// Optional build macro ELEV_OBSTRUCT_EN adds input door_obstruct, which holds
// the open timer and re-opens a closing door.
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   call_valid        : call strobe, call_floor qualifies it (out-of-range ignored)
//   emergency_stop    : level-sensitive halt
//   current_floor     : floor the car is at or last passed
//   moving_up/down    : motor commands
//   dooropen/close    : door commands
//   idle              : IDLE with nothing pending
//   pending           : latched call bitmap
// All outputs are registered.
// -----------------------------------------------------------------------------
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int  NUM_FLOORS        = 5,
    parameter int  TRAVEL_CYCLES     = 3,
    parameter int  DOOR_OPEN_CYCLES  = 4,
    parameter int  DOOR_CLOSE_CYCLES = 2,
    localparam int FW                = width_of(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  call_valid,
    input  logic [FW-1:0]         call_floor,
    input  logic                  emergency_stop,
`ifdef ELEV_OBSTRUCT_EN
    input  logic                  door_obstruct,
`endif
    output logic [FW-1:0]         current_floor,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  dooropen,
    output logic                  doorclose,
    output logic                  idle,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int TCW = width_of(TRAVEL_CYCLES);
    localparam int DCW = width_of((DOOR_OPEN_CYCLES > DOOR_CLOSE_CYCLES) ? DOOR_OPEN_CYCLES : DOOR_CLOSE_CYCLES);
    localparam logic [FW-1:0] TOP_FLOOR = FW'(NUM_FLOORS - 1);

    car_state_t            state_q, state_d;
    dir_t                  dir_q, dir_d;
    logic [FW-1:0]         floor_q, floor_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [TCW-1:0]        tcnt_q, tcnt_d;
    logic [DCW-1:0]        dcnt_q, dcnt_d;
    logic                  estop_from_move_q, estop_from_move_d;
    logic                  moving_up_q, moving_down_q, dooropen_q, doorclose_q, idle_q;
    logic                  moving_up_d, moving_down_d, dooropen_d, idle_d;

    logic                  call_ok_s, call_here_s, obstruct_s;
    logic [NUM_FLOORS-1:0] call_vec_s, open_mask_s;
    logic [FW-1:0]         step_floor_s;
    logic                  here_hit_s, here_ahead_s, here_behind_s;
    logic                  nxt_hit_s, nxt_ahead_s, nxt_behind_s;

`ifdef ELEV_OBSTRUCT_EN
    assign obstruct_s = door_obstruct;
`else
    assign obstruct_s = 1'b0;
`endif

    assign call_ok_s   = call_valid && ({1'b0, call_floor} < (FW + 1)'(NUM_FLOORS));
    assign call_vec_s  = call_ok_s ? (NUM_FLOORS'(1'b1) << call_floor) : {NUM_FLOORS{1'b0}};
    assign call_here_s = call_ok_s && (call_floor == floor_q);

    // Floor the car reaches when the current travel leg completes, clamped at the shaft ends.
    always_comb begin
        if (dir_q == UP) begin
            step_floor_s = (floor_q == TOP_FLOOR) ? floor_q : floor_q + FW'(1);
        end else begin
            step_floor_s = (floor_q == FW'(0)) ? floor_q : floor_q - FW'(1);
        end
    end

    // SCAN view at the present floor (IDLE decisions).
    scan_dir_sel #(.NUM_FLOORS(NUM_FLOORS), .FW(FW)) u_scan_here (
        .pending_i       (pending_q),
        .current_floor_i (floor_q),
        .dir_i           (dir_q),
        .hit_here_o      (here_hit_s),
        .any_ahead_o     (here_ahead_s),
        .any_behind_o    (here_behind_s)
    );

    // SCAN view at the floor being arrived at, so arrival and door opening share one edge.
    scan_dir_sel #(.NUM_FLOORS(NUM_FLOORS), .FW(FW)) u_scan_next (
        .pending_i       (pending_q),
        .current_floor_i (step_floor_s),
        .dir_i           (dir_q),
        .hit_here_o      (nxt_hit_s),
        .any_ahead_o     (nxt_ahead_s),
        .any_behind_o    (nxt_behind_s)
    );

    // Next-state logic for the car FSM, travel counter and door timer.
    always_comb begin
        state_d           = state_q;
        dir_d             = dir_q;
        floor_d           = floor_q;
        tcnt_d            = tcnt_q;
        dcnt_d            = dcnt_q;
        estop_from_move_d = estop_from_move_q;
        if (emergency_stop) begin
            // Origin is captured only on entry; travel counter stays frozen.
            state_d = ESTOP;
            if (state_q != ESTOP) begin
                estop_from_move_d = (state_q == MOVE);
            end else begin
                estop_from_move_d = estop_from_move_q;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (here_hit_s) begin
                        state_d = OPEN;
                        dcnt_d  = {DCW{1'b0}};
                    end else if (here_ahead_s) begin
                        state_d = MOVE;
                        tcnt_d  = {TCW{1'b0}};
                    end else if (here_behind_s) begin
                        state_d = MOVE;
                        dir_d   = flip_dir(dir_q);
                        tcnt_d  = {TCW{1'b0}};
                    end else begin
                        state_d = IDLE;
                    end
                end
                MOVE: begin
                    if (tcnt_q == TCW'(TRAVEL_CYCLES - 1)) begin
                        tcnt_d  = {TCW{1'b0}};
                        floor_d = step_floor_s;
                        if (nxt_hit_s) begin
                            state_d = OPEN;
                            dcnt_d  = {DCW{1'b0}};
                        end else if (nxt_ahead_s) begin
                            state_d = MOVE;
                        end else if (nxt_behind_s) begin
                            // Also turns the car inward at the shaft ends.
                            dir_d = flip_dir(dir_q);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCW'(1);
                    end
                end
                OPEN: begin
                    if (call_here_s || obstruct_s) begin
                        dcnt_d = {DCW{1'b0}};
                    end else if (dcnt_q == DCW'(DOOR_OPEN_CYCLES - 1)) begin
                        state_d = CLOSE;
                        dcnt_d  = {DCW{1'b0}};
                    end else begin
                        dcnt_d = dcnt_q + DCW'(1);
                    end
                end
                CLOSE: begin
                    if (call_here_s || obstruct_s) begin
                        state_d = OPEN;
                        dcnt_d  = {DCW{1'b0}};
                    end else if (dcnt_q == DCW'(DOOR_CLOSE_CYCLES - 1)) begin
                        state_d = IDLE;
                        dcnt_d  = {DCW{1'b0}};
                    end else begin
                        dcnt_d = dcnt_q + DCW'(1);
                    end
                end
                ESTOP: begin
                    if (estop_from_move_q) begin
                        state_d = MOVE;
                        tcnt_d  = {TCW{1'b0}};
                    end else begin
                        state_d = OPEN;
                        dcnt_d  = {DCW{1'b0}};
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Being in OPEN keeps the served floor's bit clear, absorbing same-cycle calls to it.
    assign open_mask_s   = (state_d == OPEN) ? (NUM_FLOORS'(1'b1) << floor_d) : {NUM_FLOORS{1'b0}};
    assign pending_d     = (pending_q | call_vec_s) & ~open_mask_s;

    assign moving_up_d   = (state_d == MOVE) && (dir_d == UP);
    assign moving_down_d = (state_d == MOVE) && (dir_d == DOWN);
    assign dooropen_d    = (state_d == OPEN) || ((state_d == ESTOP) && !estop_from_move_d);
    assign idle_d        = (state_d == IDLE) && (pending_d == {NUM_FLOORS{1'b0}});

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q           <= IDLE;
            dir_q             <= UP;
            floor_q           <= {FW{1'b0}};
            pending_q         <= {NUM_FLOORS{1'b0}};
            tcnt_q            <= {TCW{1'b0}};
            dcnt_q            <= {DCW{1'b0}};
            estop_from_move_q <= 1'b0;
            moving_up_q       <= 1'b0;
            moving_down_q     <= 1'b0;
            dooropen_q        <= 1'b0;
            doorclose_q       <= 1'b1;
            idle_q            <= 1'b1;
        end else begin
            state_q           <= state_d;
            dir_q             <= dir_d;
            floor_q           <= floor_d;
            pending_q         <= pending_d;
            tcnt_q            <= tcnt_d;
            dcnt_q            <= dcnt_d;
            estop_from_move_q <= estop_from_move_d;
            moving_up_q       <= moving_up_d;
            moving_down_q     <= moving_down_d;
            dooropen_q        <= dooropen_d;
            doorclose_q       <= !dooropen_d;
            idle_q            <= idle_d;
        end
    end

    assign current_floor = floor_q;
    assign pending       = pending_q;
    assign moving_up     = moving_up_q;
    assign moving_down   = moving_down_q;
    assign dooropen      = dooropen_q;
    assign doorclose     = doorclose_q;
    assign idle          = idle_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_elevator_scan_ctrl
// Self-checking bench for elevator_scan_ctrl (default parameters). A
// behavioural car model (countdown timers, floor arithmetic, call bitmap)
// predicts every output each cycle; directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_elevator_scan_ctrl;

    localparam int NF = 5;
    localparam int T  = 3;
    localparam int DO = 4;
    localparam int DC = 2;

    localparam int M_IDLE  = 0;
    localparam int M_MOVE  = 1;
    localparam int M_OPEN  = 2;
    localparam int M_CLOSE = 3;
    localparam int M_ESTOP = 4;

    logic          clk;
    logic          reset;
    logic          call_valid;
    logic [2:0]    call_floor;
    logic          emergency_stop;
    logic [2:0]    current_floor;
    logic          moving_up, moving_down, dooropen, doorclose, idle;
    logic [NF-1:0] pending;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // Model state
    int         m_mode;
    int         m_floor;
    bit         m_up;
    int         m_left;
    bit         m_estop_move;
    bit [NF-1:0] m_pend;

    elevator_scan_ctrl #(
        .NUM_FLOORS        (NF),
        .TRAVEL_CYCLES     (T),
        .DOOR_OPEN_CYCLES  (DO),
        .DOOR_CLOSE_CYCLES (DC)
    ) dut (
`ifdef ELEV_OBSTRUCT_EN
        .door_obstruct  (1'b0),
`endif
        .clk            (clk),
        .reset          (reset),
        .call_valid     (call_valid),
        .call_floor     (call_floor),
        .emergency_stop (emergency_stop),
        .current_floor  (current_floor),
        .moving_up      (moving_up),
        .moving_down    (moving_down),
        .dooropen       (dooropen),
        .doorclose      (doorclose),
        .idle           (idle),
        .pending        (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic call1(input int f);
        call_valid = 1'b1;
        call_floor = 3'(f);
        tick(1);
        call_valid = 1'b0;
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit calls_toward(input bit [NF-1:0] p, input int f, input bit up);
        for (int i = 0; i < NF; i++) begin
            if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic m_open();
        m_mode = M_OPEN;
        m_left = DO;
    endtask

    task automatic m_go();
        m_mode = M_MOVE;
        m_left = T;
    endtask

    task automatic m_step();
        bit [NF-1:0] p0 = m_pend;
        bit ok   = call_valid && (int'(call_floor) < NF);
        bit here = ok && (int'(call_floor) == m_floor);
        if (emergency_stop) begin
            if (m_mode != M_ESTOP) m_estop_move = (m_mode == M_MOVE);
            m_mode = M_ESTOP;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (p0[m_floor]) m_open();
                    else if (calls_toward(p0, m_floor, m_up)) m_go();
                    else if (calls_toward(p0, m_floor, !m_up)) begin
                        m_up = !m_up;
                        m_go();
                    end
                end
                M_MOVE: begin
                    if (m_left > 1) m_left--;
                    else begin
                        if (m_up && m_floor < NF - 1) m_floor++;
                        else if (!m_up && m_floor > 0) m_floor--;
                        if (p0[m_floor]) m_open();
                        else if (calls_toward(p0, m_floor, m_up)) m_left = T;
                        else if (calls_toward(p0, m_floor, !m_up)) begin
                            m_up   = !m_up;
                            m_left = T;
                        end else m_mode = M_IDLE;
                    end
                end
                M_OPEN: begin
                    if (here) m_left = DO;
                    else if (m_left > 1) m_left--;
                    else begin
                        m_mode = M_CLOSE;
                        m_left = DC;
                    end
                end
                M_CLOSE: begin
                    if (here) m_open();
                    else if (m_left > 1) m_left--;
                    else m_mode = M_IDLE;
                end
                M_ESTOP: begin
                    if (m_estop_move) m_go();
                    else m_open();
                end
                default: m_mode = M_IDLE;
            endcase
        end
        if (ok) m_pend[call_floor] = 1'b1;
        if (m_mode == M_OPEN) m_pend[m_floor] = 1'b0;
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            m_mode       = M_IDLE;
            m_floor      = 0;
            m_up         = 1'b1;
            m_left       = 0;
            m_estop_move = 1'b0;
            m_pend       = '0;
        end else begin
            m_step();
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            bit e_open;
            e_open = (m_mode == M_OPEN) || (m_mode == M_ESTOP && !m_estop_move);
            chk("current_floor", current_floor, m_floor);
            chk("pending", pending, m_pend);
            chk("moving_up", moving_up, (m_mode == M_MOVE) && m_up);
            chk("moving_down", moving_down, (m_mode == M_MOVE) && !m_up);
            chk("dooropen", dooropen, e_open);
            chk("doorclose", doorclose, !e_open);
            chk("idle", idle, (m_mode == M_IDLE) && (m_pend == '0));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int up_cnt, open_cnt, n, order_n;
        int order[2];
        bit prev_open;

        reset          = 1'b0;
        call_valid     = 1'b0;
        call_floor     = 3'd0;
        emergency_stop = 1'b0;
        tick(2);
        chk("reset_floor", current_floor, 0);
        chk("reset_idle", idle, 1);
        chk("reset_doorclose", doorclose, 1);
        chk("reset_dooropen", dooropen, 0);
        reset  = 1'b1;
        cmp_en = 1'b1;

        // 1: call floor 3 from reset
        call1(3);
        chk("s1_pending", pending, 5'b01000);
        up_cnt = 0;
        for (int i = 0; i < 40 && !dooropen; i++) begin
            tick(1);
            if (moving_up) up_cnt++;
        end
        chk("s1_up_cycles", up_cnt, 9);
        chk("s1_floor", current_floor, 3);
        chk("s1_pending_clr", pending, 0);
        open_cnt = 1;
        for (int i = 0; i < 20 && dooropen; i++) begin
            tick(1);
            if (dooropen) open_cnt++;
        end
        chk("s1_open_cycles", open_cnt, 4);
        tick(2);
        chk("s1_idle", idle, 1);

        // 3: out-of-range call ignored
        call1(7);
        chk("s3_pending", pending, 0);
        chk("s3_idle", idle, 1);

        // 2: at floor 2 moving up with calls 4 and 0 pending
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        call1(4);
        for (int i = 0; i < 40 && current_floor != 3'd2; i++) tick(1);
        chk("s2_at2", current_floor, 2);
        chk("s2_up_at2", moving_up, 1);
        call1(0);
        order_n   = 0;
        prev_open = dooropen;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (dooropen && !prev_open && order_n < 2) begin
                order[order_n] = current_floor;
                order_n++;
            end
            prev_open = dooropen;
        end
        chk("s2_num_stops", order_n, 2);
        chk("s2_first_stop", order[0], 4);
        chk("s2_second_stop", order[1], 0);

        // 4: emergency stop between floors 1 and 2
        call1(2);
        for (int i = 0; i < 40 && current_floor != 3'd1; i++) tick(1);
        chk("s4_at1", current_floor, 1);
        tick(1);
        emergency_stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("s4_up_off", moving_up, 0);
            chk("s4_down_off", moving_down, 0);
            chk("s4_door_shut", dooropen, 0);
        end
        emergency_stop = 1'b0;
        tick(1);
        chk("s4_resume_up", moving_up, 1);
        chk("s4_resume_floor", current_floor, 1);
        n = 0;
        for (int i = 0; i < 20 && current_floor != 3'd2; i++) begin
            tick(1);
            n++;
        end
        chk("s4_travel_after", n, 3);
        chk("s4_open_at2", dooropen, 1);

        // 5: call to own floor while closing re-opens for a full period
        for (int i = 0; i < 20 && !(doorclose && !dooropen); i++) tick(1);
        chk("s5_closing", doorclose, 1);
        call1(2);
        chk("s5_reopen", dooropen, 1);
        chk("s5_no_bit", pending[2], 0);
        open_cnt = 1;
        for (int i = 0; i < 20 && dooropen; i++) begin
            tick(1);
            if (dooropen) open_cnt++;
        end
        chk("s5_open_cycles", open_cnt, 4);
        chk("s5_no_bit_end", pending[2], 0);

        // 6: reset during OPEN at floor 4 with pending 00011
        call1(4);
        for (int i = 0; i < 40 && !(dooropen && current_floor == 3'd4); i++) tick(1);
        chk("s6_open_at4", current_floor, 4);
        call1(0);
        call1(1);
        chk("s6_pending", pending, 5'b00011);
        chk("s6_still_open", dooropen, 1);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        chk("s6_floor", current_floor, 0);
        chk("s6_pending_rst", pending, 0);
        chk("s6_dooropen", dooropen, 0);
        chk("s6_idle", idle, 1);

        // Randomised traffic, checked by the model each cycle
        for (int i = 0; i < 3000; i++) begin
            call_valid = ($urandom_range(0, 2) == 0);
            call_floor = 3'($urandom_range(0, 7));
            if (emergency_stop) emergency_stop = ($urandom_range(0, 9) < 7);
            else emergency_stop = ($urandom_range(0, 99) < 2);
            reset = ($urandom_range(0, 599) != 0);
            tick(1);
        end
        call_valid     = 1'b0;
        emergency_stop = 1'b0;
        reset          = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
